dcache_wt: RTL and testbench
============================

Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the memory-stage ALU result/store data and the backing data memory.
- Serves lw/lbu hits combinationally.
- Stalls the pipeline on read misses and on every store while a handshaked backing-memory transaction completes.
- One word per line; byte mode matches the lbu/sb AddrMode convention of the data path.

Parameters:
WIDTH, 32, data/address width in bits
IDX_BITS, 8, index width; SETS = 2**IDX_BITS lines

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous active-high reset
aluresult  input  WIDTH  byte address from execute stage
RD2  input  WIDTH  store data
MemRead  input  1  load request
MemWrite  input  1  store request
AddrMode  input  1  0 = word (lw/sw), 1 = byte (lbu/sb)
RD  output  WIDTH  load data to writeback
stall  output  1  freeze pipeline; CPU holds all inputs stable while high
mem_req  output  1  backing-memory request
mem_we  output  1  1 = write, 0 = read fill
mem_addr  output  WIDTH  word-aligned address {aluresult[31:2],2'b00}
mem_wdata  output  WIDTH  write data, byte placed in its lane for sb
mem_wstrb  output  4  byte enables (4'b1111 for sw, one-hot lane for sb, 0 for reads)
mem_rdata  input  WIDTH  fill data, valid when mem_ready
mem_ready  input  1  backing memory completes current request this cycle

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Address split: offset = aluresult[1:0]; index = aluresult[IDX_BITS+1:2]; tag = aluresult[WIDTH-1:IDX_BITS+2].
- Storage per line: valid bit, tag, WIDTH data. Hit = valid[index] && tag match.
- State machine, registered: IDLE, FILL, WRITE.
- Reset: all valid bits cleared in a single cycle; state = IDLE; mem_req = 0; mem_we = 0; mem_wstrb = 0; stall = 0; RD = 0.
- If rst is asserted while in FILL or WRITE, the transaction is abandoned: mem_req drops the next cycle and no line is updated.
- stall (combinational):
  - In IDLE: 1 when (MemRead && !hit) or MemWrite, else 0.
  - In FILL or WRITE: always 1.
- IDLE:
  - MemRead hit: RD valid in the same cycle with zero stall. Word mode returns the line data. Byte mode returns {24'h0, selected byte}.
  - MemRead miss: next state FILL.
  - MemWrite (hit or miss): next state WRITE.
  - MemRead && MemWrite together is illegal; MemWrite takes priority.
  - Neither asserted: RD = 0.
  - mem_ready is ignored in IDLE.
- FILL:
  - mem_req = 1, mem_we = 0, mem_wstrb = 0.
  - On the cycle mem_ready = 1: line gets valid = 1, tag, and mem_rdata; next state IDLE. The access then hits and stall drops.
  - Miss penalty = memory latency + 1 cycle; minimum 2 stall cycles.
- WRITE:
  - mem_req = 1, mem_we = 1; mem_addr, mem_wdata and mem_wstrb are driven from the held inputs.
  - On the cycle mem_ready = 1:
    - If the line hits: merge the written bytes (all four for sw, lane offset only for sb) into the line. Valid and tag are unchanged.
    - If it misses: the cache is unchanged (no allocate).
    - Next state IDLE. Stall drops in that IDLE cycle because MemWrite is expected to deassert as the pipeline advances.
- Byte lanes are little-endian: lane n = bits [8n+7:8n].
- sb replicates nothing; the byte sits at lane offset and other lanes of mem_wdata are 0.
- Unaligned sw/lw are not supported; offset is ignored in word mode.
- Index wrap: addresses differing only in tag alias to the same line and evict on fill.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined: adds 32-bit output counters hit_count, miss_count and write_count.
  - Cleared on rst.
  - hit_count increments once per IDLE MemRead hit cycle.
  - miss_count increments on each IDLE→FILL transition.
  - write_count increments on each IDLE→WRITE transition.
  - Counters saturate at 32'hFFFFFFFF.
- When undefined: these ports and their logic do not exist; cache behaviour is identical.

Test Plan:
- Reset, then lw 0x00010000 with backing memory holding 0xDEADBEEF and 2-cycle ready → stall for 3 cycles, mem_req/mem_we=0 seen, then RD=0xDEADBEEF with stall=0; immediate repeat lw → hit, zero stall.
- After fill of 0x00010000, lbu 0x00010002 → RD=0x000000AD same cycle, no mem_req.
- sb 0x00010001 with RD2=0x55 on a cached line → mem_wstrb=4'b0010, mem_wdata=0x00005500; then lw → 0xDEAD55EF from cache without fill.
- sw 0x00020000 with 0x12345678 on a miss → backing write occurs; following lw 0x00020000 misses and fills (no allocate verified).
- Alias: fill 0x00010000, then lw 0x00010400 (same index with IDX_BITS=8) → miss/evict; lw 0x00010000 misses again.
- Assert rst during FILL before mem_ready → mem_req 0 next cycle, state IDLE; lw of the same address misses again.

Source files
------------

// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, no-write-allocate data cache.
// Define DCACHE_STATS_EN to add hit_count/miss_count/write_count outputs.
module dcache_wt #(
    parameter int WIDTH    = 32,
    parameter int IDX_BITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] aluresult,
    input  logic [WIDTH-1:0] RD2,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             AddrMode,
    output logic [WIDTH-1:0] RD,
    output logic             stall,
`ifdef DCACHE_STATS_EN
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count,
    output logic [31:0]      write_count,
`endif
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready
);

    localparam int SETS  = 1 << IDX_BITS;
    localparam int TAG_W = WIDTH - IDX_BITS - 2;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE
    } state_t;

    state_t               state_q;
    logic [SETS-1:0]      valid_q;
    logic [TAG_W-1:0]     tag_q  [SETS];
    logic [WIDTH-1:0]     data_q [SETS];

    logic [IDX_BITS-1:0]  idx;
    logic [TAG_W-1:0]     tag;
    logic [1:0]           off;
    logic [WIDTH-1:0]     line;
    logic [WIDTH-1:0]     byte_sh;
    logic [WIDTH-1:0]     wr_data;
    logic [WIDTH-1:0]     wr_mask;
    logic [WIDTH-1:0]     merged;
    logic [3:0]           wr_strb;
    logic                 hit;
    logic                 is_idle;
    logic                 rd_hit;

    assign idx     = aluresult[IDX_BITS+1:2];
    assign tag     = aluresult[WIDTH-1:IDX_BITS+2];
    assign off     = aluresult[1:0];
    assign line    = data_q[idx];
    assign hit     = valid_q[idx] && (tag_q[idx] == tag);
    assign is_idle = (state_q == IDLE);
    assign rd_hit  = is_idle && MemRead && !MemWrite && hit;
    assign byte_sh = line >> {off, 3'b000};

    // Store lane placement and the merge of written bytes into a hit line
    always_comb begin
        wr_strb = 4'b1111;
        wr_data = RD2;
        if (AddrMode) begin
            wr_strb = 4'b0001 << off;
            wr_data = {{(WIDTH-8){1'b0}}, RD2[7:0]} << {off, 3'b000};
        end
        wr_mask = '0;
        for (int i = 0; i < 4; i++) begin
            wr_mask[8*i +: 8] = {8{wr_strb[i]}};
        end
        merged = (line & ~wr_mask) | (wr_data & wr_mask);
    end

    // CPU-facing read data and stall; memory-facing address and write data
    always_comb begin
        RD = '0;
        if (rd_hit) begin
            RD = AddrMode ? {{(WIDTH-8){1'b0}}, byte_sh[7:0]} : line;
        end
        stall     = is_idle ? ((MemRead && !hit) || MemWrite) : 1'b1;
        mem_addr  = {aluresult[WIDTH-1:2], 2'b00};
        mem_wdata = mem_we ? wr_data : '0;
        mem_wstrb = mem_we ? wr_strb : 4'b0000;
    end

    // Controller FSM with registered request outputs and line updates
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (MemWrite) begin
                        state_q <= WRITE;
                        mem_req <= 1'b1;
                        mem_we  <= 1'b1;
                    end else if (MemRead && !hit) begin
                        state_q <= FILL;
                        mem_req <= 1'b1;
                        mem_we  <= 1'b0;
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        state_q      <= IDLE;
                        mem_req      <= 1'b0;
                        valid_q[idx] <= 1'b1;
                        tag_q[idx]   <= tag;
                        data_q[idx]  <= mem_rdata;
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        state_q <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (hit) begin
                            data_q[idx] <= merged;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic go_fill;
    logic go_write;

    assign go_fill  = is_idle && MemRead && !MemWrite && !hit;
    assign go_write = is_idle && MemWrite;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count   <= '0;
            miss_count  <= '0;
            write_count <= '0;
        end else begin
            if (rd_hit && hit_count != 32'hFFFF_FFFF)
                hit_count <= hit_count + 32'd1;
            if (go_fill && miss_count != 32'hFFFF_FFFF)
                miss_count <= miss_count + 32'd1;
            if (go_write && write_count != 32'hFFFF_FFFF)
                write_count <= write_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// tb_dcache_wt: scoreboard bench for dcache_wt with a
// latency-programmable backing memory model.
module tb_dcache_wt;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] aluresult;
    logic [31:0] RD2;
    logic        MemRead;
    logic        MemWrite;
    logic        AddrMode;
    logic [31:0] RD;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic [31:0] write_count;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int lat   = 2;
    int n_rds = 0;
    int n_mis = 0;
    int n_wrs = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mem_model [logic [29:0]];

    dcache_wt dut (
        .clk       (clk),
        .rst       (rst),
        .aluresult (aluresult),
        .RD2       (RD2),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .AddrMode  (AddrMode),
        .RD        (RD),
        .stall     (stall),
`ifdef DCACHE_STATS_EN
        .hit_count   (hit_count),
        .miss_count  (miss_count),
        .write_count (write_count),
`endif
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a[31:2])) return mem_model[a[31:2]];
        return 32'h0;
    endfunction

    // Backing memory: ready after lat request cycles, commits writes.
    initial begin
        int cnt;
        logic [31:0] w;
        cnt = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_ready = 1'b0;
            if (mem_req && !rst) begin
                cnt++;
                if (cnt >= lat) begin
                    cnt = 0;
                    mem_ready = 1'b1;
                    if (mem_we) begin
                        w = mem_rd(mem_addr);
                        for (int i = 0; i < 4; i++)
                            if (mem_wstrb[i])
                                w[8*i +: 8] = mem_wdata[8*i +: 8];
                        mem_model[mem_addr[31:2]] = w;
                    end else begin
                        mem_rdata = mem_rd(mem_addr);
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic access(input bit wr, input bit bm,
                          input logic [31:0] a,
                          input logic [31:0] d,
                          input int exp_st,
                          input string tag);
        int n;
        bit hs, seen, we_bad;
        logic [31:0] w, sh, e_wd;
        logic [3:0] e_st;
        w  = mem_rd(a);
        sh = w >> {a[1:0], 3'b000};
        if (!wr) exp_q.push_back(bm ? {24'h0, sh[7:0]} : w);
        e_st = bm ? (4'b0001 << a[1:0]) : 4'b1111;
        e_wd = bm ? ({24'h0, d[7:0]} << {a[1:0], 3'b000}) : d;
        @(posedge clk); #1;
        aluresult = a;
        RD2       = d;
        MemRead   = !wr;
        MemWrite  = wr;
        AddrMode  = bm;
        n = 0; hs = 0; seen = 0; we_bad = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            n++;
            if (mem_req) begin
                seen = 1;
                if (mem_we !== wr) we_bad = 1;
            end
            if (wr && mem_req && mem_ready) begin
                hs = 1;
                check({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
                check({tag, "_wstrb"}, {28'h0, mem_wstrb}, {28'h0, e_st});
                check({tag, "_wdata"}, mem_wdata, e_wd);
            end
            if (n > 40) begin
                check({tag, "_timeout"}, 32'd1, 32'd0);
                break;
            end
            @(posedge clk); #1;
            if (hs) MemWrite = 1'b0;
        end
        check({tag, "_stalls"}, n, exp_st);
        check({tag, "_req"}, {31'h0, seen}, {31'h0, exp_st > 0});
        check({tag, "_we"}, {31'h0, we_bad}, 32'd0);
        if (wr) begin
            check({tag, "_hs"}, {31'h0, hs}, 32'd1);
            n_wrs++;
        end else begin
            if (exp_q.size() == 0) check({tag, "_empty"}, 32'd1, 32'd0);
            else check({tag, "_rd"}, RD, exp_q.pop_front());
            n_rds++;
            if (exp_st > 0) n_mis++;
        end
        @(posedge clk); #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        AddrMode = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        aluresult = '0; RD2 = '0;
        MemRead = 1'b0; MemWrite = 1'b0; AddrMode = 1'b0;
        mem_model[30'h0000_4000] = 32'hDEAD_BEEF;
        mem_model[30'h0000_4100] = 32'hCAFE_F00D;
        mem_model[30'h0000_8000] = 32'h1111_1111;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_stall", {31'h0, stall}, 32'd0);
        check("rst_req", {31'h0, mem_req}, 32'd0);
        check("rst_we", {31'h0, mem_we}, 32'd0);
        check("rst_wstrb", {28'h0, mem_wstrb}, 32'd0);
        check("rst_rd", RD, 32'd0);

        lat = 2;
        access(0, 0, 32'h0001_0000, 0, 3, "lw_miss");
        access(0, 0, 32'h0001_0000, 0, 0, "lw_hit");
        access(0, 1, 32'h0001_0002, 0, 0, "lbu_hit");
        access(1, 1, 32'h0001_0001, 32'hAAAA_AA55, 3, "sb_hit");
        access(0, 0, 32'h0001_0000, 0, 0, "lw_merged");
        check("merged_val", mem_rd(32'h0001_0000), 32'hDEAD_55EF);
        access(1, 0, 32'h0002_0000, 32'h1234_5678, 3, "sw_miss");
        access(0, 0, 32'h0002_0000, 0, 3, "lw_noalloc");
        access(0, 0, 32'h0001_0400, 0, 3, "lw_alias");
        access(0, 0, 32'h0001_0000, 0, 3, "lw_evicted");

        lat = 1;
        access(0, 0, 32'h0001_0400, 0, 2, "lw_minlat");
        access(1, 1, 32'h0001_0403, 32'h0000_0077, 2, "sb_lane3");
        access(0, 0, 32'h0001_0400, 0, 0, "lw_lane3");
        access(0, 0, 32'h0001_0402, 0, 0, "lw_offign");
        access(0, 1, 32'h0001_0403, 0, 0, "lbu_lane3");

`ifdef DCACHE_STATS_EN
        check("hit_count", hit_count, n_rds);
        check("miss_count", miss_count, n_mis);
        check("write_count", write_count, n_wrs);
`endif

        lat = 5;
        @(posedge clk); #1;
        aluresult = 32'h0001_0000;
        MemRead   = 1'b1;
        AddrMode  = 1'b0;
        @(negedge clk);
        check("rstf_stall", {31'h0, stall}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rstf_req", {31'h0, mem_req}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        MemRead = 1'b0;
        @(negedge clk);
        check("rstf_req_drop", {31'h0, mem_req}, 32'd0);
        check("rstf_stall_drop", {31'h0, stall}, 32'd0);

        lat = 2;
        access(0, 0, 32'h0001_0000, 0, 3, "lw_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
